// File: rtl/trng_pkg.sv
// ============================================================================
// Module      : trng_pkg
// Description : Shared state encoding and default widths for the TRNG
//               sequencer and the register map.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package trng_pkg;

    localparam int TMW_WIDTH    = 12;
    localparam int WARMUP_WIDTH = 8;
    localparam int WORD_WIDTH   = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        WINDOW = 2'd2,
        OUTPUT = 2'd3
    } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/trng_window_timer.sv
// ============================================================================
// Module      : trng_window_timer
// Description : Loadable up/down cycle counter with clear and terminal count.
//               Up mode wraps to zero at limit_i; down mode holds at limit_i.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module trng_window_timer #(
    parameter int WIDTH      = 8,
    parameter bit COUNT_DOWN = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        tc_o = (count_q == limit_i);
    end

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            if (tc_o) begin
                count_d = COUNT_DOWN ? count_q : '0;
            end else begin
                count_d = COUNT_DOWN ? (count_q - WIDTH'(1)) : (count_q + WIDTH'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/trng_sequencer.sv
// ============================================================================
// Module      : trng_sequencer
// Description : TRNG acquisition sequencer: RO warm-up, sampling windows,
//               word assembly and valid/ready output. Optional von Neumann
//               debias enabled by macro TRNG_SEQ_VN_DEBIAS_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module trng_sequencer #(
    parameter int TMW_WIDTH    = trng_pkg::TMW_WIDTH,
    parameter int WARMUP_WIDTH = trng_pkg::WARMUP_WIDTH,
    parameter int WORD_WIDTH   = trng_pkg::WORD_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [TMW_WIDTH-1:0]    tmw_max_i,
    input  logic [WARMUP_WIDTH-1:0] warmup_i,
    input  logic                    ro_bit_i,
    output logic                    ro_en_o,
    output logic                    sample_o,
    output logic                    busy_o,
    output logic [WORD_WIDTH-1:0]   word_o,
    output logic                    word_valid_o,
    input  logic                    word_ready_i
);

    import trng_pkg::*;

    localparam int BCW = $clog2(WORD_WIDTH + 1);

    seq_state_e            state_q, state_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                  valid_q, valid_d;
    logic                  sample_q, sample_d;
    logic [TMW_WIDTH-1:0]  win_last_q, win_last_d;

    logic                    w_warm_load;
    logic                    w_warm_en;
    logic                    w_warm_tc;
    logic                    w_win_clr;
    logic                    w_win_en;
    logic                    w_win_tc;
    logic                    w_push;
    logic                    w_push_bit;
    logic [WARMUP_WIDTH-1:0] w_warm_val;
    logic [TMW_WIDTH-1:0]    w_win_last;

`ifdef TRNG_SEQ_VN_DEBIAS_EN
    logic pair_q, pair_d;
    logic first_q, first_d;
`endif

    // Zero-length settings are clamped to one.
    always_comb begin
        w_warm_val = (warmup_i == '0) ? WARMUP_WIDTH'(1) : warmup_i;
        w_win_last = (tmw_max_i == '0) ? '0 : (tmw_max_i - TMW_WIDTH'(1));
    end

    // Warm-up counts down from W to 0; the load cycle is part of the settle time.
    trng_window_timer #(
        .WIDTH      (WARMUP_WIDTH),
        .COUNT_DOWN (1'b1)
    ) u_warm_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (1'b0),
        .load_i     (w_warm_load),
        .load_val_i (w_warm_val),
        .en_i       (w_warm_en),
        .limit_i    ('0),
        .tc_o       (w_warm_tc)
    );

    trng_window_timer #(
        .WIDTH      (TMW_WIDTH),
        .COUNT_DOWN (1'b0)
    ) u_win_timer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (w_win_clr),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (w_win_en),
        .limit_i    (win_last_q),
        .tc_o       (w_win_tc)
    );

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        word_d      = word_q;
        bit_cnt_d   = bit_cnt_q;
        valid_d     = valid_q;
        sample_d    = 1'b0;
        win_last_d  = win_last_q;
        w_warm_load = 1'b0;
        w_warm_en   = 1'b0;
        w_win_clr   = 1'b0;
        w_win_en    = 1'b0;
        w_push      = 1'b0;
        w_push_bit  = ro_bit_i;
`ifdef TRNG_SEQ_VN_DEBIAS_EN
        pair_d      = pair_q;
        first_d     = first_q;
`endif

        case (state_q)
            IDLE: begin
                bit_cnt_d = '0;
                shift_d   = '0;
                w_win_clr = 1'b1;
`ifdef TRNG_SEQ_VN_DEBIAS_EN
                pair_d    = 1'b0;
`endif
                if (start_i) begin
                    state_d     = WARMUP;
                    w_warm_load = 1'b1;
                    win_last_d  = w_win_last;
                end
            end
            WARMUP: begin
                if (!start_i) begin
                    state_d = IDLE;
                end else if (w_warm_tc) begin
                    state_d   = WINDOW;
                    w_win_clr = 1'b1;
`ifdef TRNG_SEQ_VN_DEBIAS_EN
                    pair_d    = 1'b0;
`endif
                end else begin
                    w_warm_en = 1'b1;
                end
            end
            WINDOW: begin
                // Abort takes priority over a coincident sample.
                if (!start_i) begin
                    state_d = IDLE;
                end else begin
                    w_win_en = 1'b1;
                    if (w_win_tc) begin
                        sample_d = 1'b1;
`ifdef TRNG_SEQ_VN_DEBIAS_EN
                        pair_d = ~pair_q;
                        if (!pair_q) begin
                            first_d = ro_bit_i;
                        end else if (first_q != ro_bit_i) begin
                            w_push     = 1'b1;
                            w_push_bit = first_q;
                        end
`else
                        w_push = 1'b1;
`endif
                    end
                end
            end
            OUTPUT: begin
                if (valid_q && word_ready_i) begin
                    valid_d   = 1'b0;
                    bit_cnt_d = '0;
                    w_win_clr = 1'b1;
`ifdef TRNG_SEQ_VN_DEBIAS_EN
                    pair_d    = 1'b0;
`endif
                    state_d   = start_i ? WINDOW : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_push) begin
            shift_d   = {shift_q[WORD_WIDTH-2:0], w_push_bit};
            bit_cnt_d = bit_cnt_q + BCW'(1);
            if (bit_cnt_q == BCW'(WORD_WIDTH - 1)) begin
                word_d  = {shift_q[WORD_WIDTH-2:0], w_push_bit};
                valid_d = 1'b1;
                state_d = OUTPUT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            word_q     <= '0;
            bit_cnt_q  <= '0;
            valid_q    <= 1'b0;
            sample_q   <= 1'b0;
            win_last_q <= '0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            word_q     <= word_d;
            bit_cnt_q  <= bit_cnt_d;
            valid_q    <= valid_d;
            sample_q   <= sample_d;
            win_last_q <= win_last_d;
        end
    end

`ifdef TRNG_SEQ_VN_DEBIAS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_q  <= 1'b0;
            first_q <= 1'b0;
        end else begin
            pair_q  <= pair_d;
            first_q <= first_d;
        end
    end
`endif

    always_comb begin
        ro_en_o      = (state_q == WARMUP) || (state_q == WINDOW);
        busy_o       = (state_q != IDLE);
        sample_o     = sample_q;
        word_o       = word_q;
        word_valid_o = valid_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_trng_sequencer.sv
// ============================================================================
// Module      : tb_trng_sequencer
// Description : Directed self-checking bench for trng_sequencer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_trng_sequencer;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [11:0] tmw_max_i;
    logic [7:0]  warmup_i;
    logic        ro_bit_i;
    logic        ro_en_o;
    logic        sample_o;
    logic        busy_o;
    logic [31:0] word_o;
    logic        word_valid_o;
    logic        word_ready_i;

    int n_checks = 0;
    int n_fail   = 0;
    int ro_mode  = 0;
    int samp_idx = 0;
    int pulse_cnt = 0;

    trng_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .tmw_max_i    (tmw_max_i),
        .warmup_i     (warmup_i),
        .ro_bit_i     (ro_bit_i),
        .ro_en_o      (ro_en_o),
        .sample_o     (sample_o),
        .busy_o       (busy_o),
        .word_o       (word_o),
        .word_valid_o (word_valid_o),
        .word_ready_i (word_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode 0: 1,0,1,0...  1: all ones  2: pairs 11,01,00,10  3: 0,1,0,1...
    function automatic logic ro_for(input int mode, input int k);
        logic [7:0] pat;
        pat = 8'b0100_1011;
        case (mode)
            0:       return (k % 2) == 0;
            1:       return 1'b1;
            2:       return pat[k % 8];
            default: return (k % 2) == 1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        if (sample_o) begin
            pulse_cnt++;
            samp_idx++;
            ro_bit_i = ro_for(ro_mode, samp_idx);
        end
    endtask

    task automatic begin_run(input int mode, input logic [7:0] w, input logic [11:0] m);
        samp_idx  = 0;
        pulse_cnt = 0;
        ro_mode   = mode;
        ro_bit_i  = ro_for(mode, 0);
        warmup_i  = w;
        tmw_max_i = m;
        start_i   = 1'b1;
    endtask

    // Edge index 0 is the first posedge after the call; -1 means timeout.
    task automatic wait_valid(input int limit, input int first_cap, input int period,
                              output int edges, output int bad);
        edges = -1;
        bad   = 0;
        for (int e = 0; e < limit; e++) begin
            step();
            if (sample_o && (e < first_cap || ((e - first_cap) % period) != 0)) bad++;
            if (word_valid_o) begin
                edges = e;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; word_ready_i = 1'b0; ro_bit_i = 1'b0;
        tmw_max_i = '0; warmup_i = '0;
        #12;
        n_checks++;
        if ({ro_en_o, sample_o, busy_o, word_valid_o, word_o} !== 36'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", {ro_en_o, sample_o, busy_o, word_valid_o, word_o});
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_hold: busy got %b expected 0", busy_o);
        end
    endtask

    task automatic test_basic_word();
        int e, bad;
        begin_run(0, 8'd4, 12'd3);
        wait_valid(300, 8, 3, e, bad);
        n_checks++;
        if (e !== 101) begin n_fail++; $display("FAIL basic_valid_edge: got %0d expected 101", e); end
        n_checks++;
        if (word_o !== 32'hAAAAAAAA) begin n_fail++; $display("FAIL basic_word: got %h expected aaaaaaaa", word_o); end
        n_checks++;
        if (pulse_cnt !== 32) begin n_fail++; $display("FAIL basic_pulses: got %0d expected 32", pulse_cnt); end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL basic_pulse_timing: got %0d stray expected 0", bad); end
        n_checks++;
        if ({ro_en_o, busy_o} !== 2'b01) begin n_fail++; $display("FAIL basic_output_state: ro_en/busy got %b expected 01", {ro_en_o, busy_o}); end
    endtask

    task automatic test_backpressure();
        int e, bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (word_o !== 32'hAAAAAAAA || word_valid_o !== 1'b1 || ro_en_o !== 1'b0 || sample_o !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin n_fail++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad); end
        word_ready_i = 1'b1;
        step();
        word_ready_i = 1'b0;
        n_checks++;
        if ({ro_en_o, word_valid_o} !== 2'b10) begin n_fail++; $display("FAIL bp_handshake: ro_en/valid got %b expected 10", {ro_en_o, word_valid_o}); end
        pulse_cnt = 0;
        wait_valid(200, 2, 3, e, bad);
        n_checks++;
        if (e !== 95) begin n_fail++; $display("FAIL bp_next_valid: got %0d expected 95", e); end
        n_checks++;
        if (word_o !== 32'hAAAAAAAA || pulse_cnt !== 32) begin
            n_fail++; $display("FAIL bp_second_word: got %h/%0d expected aaaaaaaa/32", word_o, pulse_cnt);
        end
        word_ready_i = 1'b1;
        start_i = 1'b0;
        step();
        word_ready_i = 1'b0;
        n_checks++;
        if ({busy_o, word_valid_o} !== 2'b00) begin n_fail++; $display("FAIL bp_to_idle: busy/valid got %b expected 00", {busy_o, word_valid_o}); end
    endtask

    task automatic test_abort();
        int e, bad;
        begin_run(1, 8'd4, 12'd3);
        for (int i = 0; i < 100 && pulse_cnt < 10; i++) step();
        n_checks++;
        if (pulse_cnt !== 10) begin n_fail++; $display("FAIL abort_pre_samples: got %0d expected 10", pulse_cnt); end
        step();
        step();
        // Next edge is a sample edge; the abort must win.
        start_i = 1'b0;
        step();
        n_checks++;
        if ({busy_o, ro_en_o, sample_o} !== 3'b000) begin
            n_fail++; $display("FAIL abort_idle: busy/ro_en/sample got %b expected 000", {busy_o, ro_en_o, sample_o});
        end
        begin_run(3, 8'd4, 12'd3);
        wait_valid(300, 8, 3, e, bad);
        n_checks++;
        if (e !== 101) begin n_fail++; $display("FAIL abort_restart_edge: got %0d expected 101", e); end
        n_checks++;
        if (word_o !== 32'h55555555) begin n_fail++; $display("FAIL abort_fresh_word: got %h expected 55555555", word_o); end
        word_ready_i = 1'b1;
        start_i = 1'b0;
        step();
        word_ready_i = 1'b0;
    endtask

    task automatic test_clamp();
        int e, bad;
        begin_run(0, 8'd0, 12'd0);
        wait_valid(100, 3, 1, e, bad);
        n_checks++;
        if (e !== 34) begin n_fail++; $display("FAIL clamp_valid_edge: got %0d expected 34", e); end
        n_checks++;
        if (word_o !== 32'hAAAAAAAA || pulse_cnt !== 32 || bad !== 0) begin
            n_fail++; $display("FAIL clamp_word: got %h/%0d/%0d expected aaaaaaaa/32/0", word_o, pulse_cnt, bad);
        end
    endtask

    task automatic test_async_reset();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({ro_en_o, sample_o, busy_o, word_valid_o, word_o} !== 36'h0) begin
            n_fail++; $display("FAIL async_reset: got %h expected 0", {ro_en_o, sample_o, busy_o, word_valid_o, word_o});
        end
        @(negedge clk);
        start_i = 1'b0;
        rst = 1'b0;
        step();
        n_checks++;
        if ({busy_o, word_valid_o} !== 2'b00) begin n_fail++; $display("FAIL async_reset_idle: got %b expected 00", {busy_o, word_valid_o}); end
        start_i = 1'b1;
        step();
        n_checks++;
        if ({busy_o, ro_en_o} !== 2'b11) begin n_fail++; $display("FAIL async_reset_restart: got %b expected 11", {busy_o, ro_en_o}); end
        start_i = 1'b0;
        step();
    endtask

`ifdef TRNG_SEQ_VN_DEBIAS_EN
    task automatic test_vn_debias();
        int e, bad;
        begin_run(2, 8'd4, 12'd3);
        wait_valid(800, 8, 3, e, bad);
        n_checks++;
        if (e !== 389) begin n_fail++; $display("FAIL vn_valid_edge: got %0d expected 389", e); end
        n_checks++;
        if (word_o !== 32'h55555555) begin n_fail++; $display("FAIL vn_word: got %h expected 55555555", word_o); end
        n_checks++;
        if (pulse_cnt !== 128 || bad !== 0) begin n_fail++; $display("FAIL vn_pulses: got %0d/%0d expected 128/0", pulse_cnt, bad); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef TRNG_SEQ_VN_DEBIAS_EN
        test_vn_debias();
`else
        test_basic_word();
        test_backpressure();
        test_abort();
        test_clamp();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
